// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (1), data LSB first,
// optional even parity, stop bit (0); each line bit is held CLKS_PER_BIT clocks.
module serial_tx #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          PARITY_EN    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             tx_out,
   output logic             busy,
   output logic             tx_done
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_nxt;
   logic             parity_q;
   logic [IDX_W-1:0] bit_idx_q;
   logic [CNT_W-1:0] clk_cnt_q;

   assign in_ready  = (state_q == StIdle) && !rst;
   // Shifted copy used to pick the next data bit without a constant index past WIDTH-1.
   assign shift_nxt = shift_q >> 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bit_idx_q <= '0;
         clk_cnt_q <= '0;
         tx_out    <= 1'b0;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state_q == StIdle) begin
            if (in_valid && in_ready) begin
               shift_q   <= in_data;
               parity_q  <= ^in_data;
               state_q   <= StStart;
               tx_out    <= 1'b1;
               busy      <= 1'b1;
               clk_cnt_q <= '0;
            end else begin
               tx_out <= 1'b0;
               busy   <= 1'b0;
            end
         end else if (clk_cnt_q != CNT_LAST) begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
         end else begin
            clk_cnt_q <= '0;
            case (state_q)
               StStart: begin
                  state_q   <= StData;
                  tx_out    <= shift_q[0];
                  bit_idx_q <= '0;
               end
               StData: begin
                  if (bit_idx_q != IDX_LAST) begin
                     shift_q   <= shift_nxt;
                     tx_out    <= shift_nxt[0];
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end else if (PARITY_EN) begin
                     state_q <= StParity;
                     tx_out  <= parity_q;
                  end else begin
                     state_q <= StStop;
                     tx_out  <= 1'b0;
                  end
               end
               StParity: begin
                  state_q <= StStop;
                  tx_out  <= 1'b0;
               end
               StStop: begin
                  state_q <= StIdle;
                  tx_out  <= 1'b0;
                  busy    <= 1'b0;
                  tx_done <= 1'b1;
               end
               default: begin
                  state_q <= StIdle;
                  tx_out  <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three configurations share one stimulus stream and are each
// checked every cycle against a queue-based frame model, plus literal frame pins.
module tb_serial_tx;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic [2:0] rdy, line, bsy, dn;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   bit cap_line [3][131];
   bit cap_bsy  [3][131];
   bit cap_dn   [3][131];

   always #5 clk = ~clk;

   // Config 0: CLKS_PER_BIT=4 parity on; 1: CLKS_PER_BIT=4 parity off; 2: CLKS_PER_BIT=1 parity on.
   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int unsigned CPB = (g == 2) ? 1 : 4;
      localparam bit          PE  = (g != 1);

      serial_tx #(
         .WIDTH       (8),
         .CLKS_PER_BIT(CPB),
         .PARITY_EN   (PE)
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .in_valid(in_valid),
         .in_data (in_data),
         .in_ready(rdy[g]),
         .tx_out  (line[g]),
         .busy    (bsy[g]),
         .tx_done (dn[g])
      );

      // Model: on accept, the whole frame is expanded into one queue entry per line cycle.
      bit m_line = 1'b0;
      bit m_busy = 1'b0;
      bit m_done = 1'b0;
      bit q[$];

      initial forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            m_line = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
         end else begin
            m_done = 1'b0;
            if (m_busy) begin
               if (q.size() > 0) begin
                  m_line = q.pop_front();
               end else begin
                  m_busy = 1'b0;
                  m_line = 1'b0;
                  m_done = 1'b1;
               end
            end else if (in_valid) begin
               for (int r = 0; r < int'(CPB); r++) q.push_back(1'b1);
               for (int i = 0; i < 8; i++)
                  for (int r = 0; r < int'(CPB); r++) q.push_back(in_data[i]);
               if (PE)
                  for (int r = 0; r < int'(CPB); r++) q.push_back(^in_data);
               for (int r = 0; r < int'(CPB); r++) q.push_back(1'b0);
               m_line = q.pop_front();
               m_busy = 1'b1;
            end else begin
               m_line = 1'b0;
            end
         end
      end

      initial forever begin
         @(negedge clk);
         if (chk_en) begin
            vectors++;
            if (line[g] !== m_line || bsy[g] !== m_busy || dn[g] !== m_done ||
                rdy[g] !== (!rst && !m_busy)) begin
               miscompares++;
               $display("FAIL model_cfg%0d t=%0t: tx_out/busy/tx_done/in_ready got %b%b%b%b expected %b%b%b%b",
                        g, $time, line[g], bsy[g], dn[g], rdy[g],
                        m_line, m_busy, m_done, !rst && !m_busy);
            end
         end
      end
   end

   task automatic pin(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic start_frame(input logic [7:0] d);
      @(negedge clk);
      #2;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
   endtask

   // Cycle k is the k-th cycle after the accept edge.
   task automatic capture(input int n, input bit hold, input logic [7:0] nd);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            cap_line[g][k] = line[g];
            cap_bsy[g][k]  = bsy[g];
            cap_dn[g][k]   = dn[g];
         end
         if (k == 1) begin
            #2;
            in_valid = hold;
            in_data  = nd;
         end
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while (bsy != 3'b000 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (bsy != 3'b000) pin("idle_timeout", int'(bsy), 0);
      @(negedge clk);
   endtask

   function automatic int count_done(input int g, input int n);
      int c = 0;
      for (int k = 1; k <= n; k++) c += int'(cap_dn[g][k]);
      return c;
   endfunction

   logic [10:0] fa5 = 11'b00101001011;  // 0xA5 frame slots, bit 0 = start
   logic [10:0] f80 = 11'b01100000001;  // 0x80 frame slots with parity

   initial begin
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         pin($sformatf("rst_line%0d", g), int'(line[g]), 0);
         pin($sformatf("rst_busy%0d", g), int'(bsy[g]), 0);
         pin($sformatf("rst_done%0d", g), int'(dn[g]), 0);
         pin($sformatf("rst_ready%0d", g), int'(rdy[g]), 0);
      end
      #2;
      rst = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) pin($sformatf("ready_after_rst%0d", g), int'(rdy[g]), 1);

      // 0xA5; data changed right after accept must not matter
      start_frame(8'hA5);
      capture(60, 1'b0, 8'h5A);
      for (int k = 1; k <= 44; k++) pin($sformatf("a5_line_c%0d", k), int'(cap_line[0][k]),
                                         int'(fa5[(k - 1) / 4]));
      pin("a5_busy44", int'(cap_bsy[0][44]), 1);
      pin("a5_busy45", int'(cap_bsy[0][45]), 0);
      pin("a5_done45", int'(cap_dn[0][45]), 1);
      pin("a5_done_count", count_done(0, 60), 1);
      pin("a5_nopar_done41", int'(cap_dn[1][41]), 1);
      pin("a5_nopar_busy40", int'(cap_bsy[1][40]), 1);
      for (int k = 1; k <= 11; k++) pin($sformatf("a5_cpb1_c%0d", k), int'(cap_line[2][k]),
                                         int'(fa5[k - 1]));
      pin("a5_cpb1_done12", int'(cap_dn[2][12]), 1);
      wait_idle();

      // 0x07: parity slot is 1; without parity that slot is the stop bit
      start_frame(8'h07);
      capture(50, 1'b0, 8'h00);
      pin("p07_parity", int'(cap_line[0][38]), 1);
      pin("p07_nopar_stop", int'(cap_line[1][38]), 0);
      pin("p07_nopar_done41", int'(cap_dn[1][41]), 1);
      pin("p07_done45", int'(cap_dn[0][45]), 1);
      wait_idle();

      // 0x80 at one clock per bit
      start_frame(8'h80);
      capture(14, 1'b0, 8'h00);
      for (int k = 1; k <= 11; k++) pin($sformatf("x80_cpb1_c%0d", k), int'(cap_line[2][k]),
                                         int'(f80[k - 1]));
      pin("x80_cpb1_done12", int'(cap_dn[2][12]), 1);
      wait_idle();

      // Back-to-back with in_valid held: 0x3C, then 0xC3
      start_frame(8'h3C);
      capture(100, 1'b1, 8'hC3);
      pin("b2b_stop44", int'(cap_line[0][44]), 0);
      pin("b2b_gap45", int'(cap_line[0][45]), 0);
      pin("b2b_done45", int'(cap_dn[0][45]), 1);
      pin("b2b_start46", int'(cap_line[0][46]), 1);
      pin("b2b_f1_bit0", int'(cap_line[0][5]), 0);
      pin("b2b_f1_bit2", int'(cap_line[0][13]), 1);
      pin("b2b_f2_bit0", int'(cap_line[0][50]), 1);
      pin("b2b_f2_bit2", int'(cap_line[0][58]), 0);
      #2;
      in_valid = 1'b0;
      wait_idle();

      // Reset in the middle of the data bits of 0xFF
      start_frame(8'hFF);
      capture(10, 1'b0, 8'h00);
      pin("mid_line_before", int'(line[0]), 1);
      #2;
      rst = 1'b1;
      #1;
      for (int g = 0; g < 3; g++) begin
         pin($sformatf("mid_rst_line%0d", g), int'(line[g]), 0);
         pin($sformatf("mid_rst_busy%0d", g), int'(bsy[g]), 0);
         pin($sformatf("mid_rst_done%0d", g), int'(dn[g]), 0);
         pin($sformatf("mid_rst_ready%0d", g), int'(rdy[g]), 0);
      end
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      pin("mid_ready_after", int'(rdy[0]), 1);
      wait_idle();

      start_frame(8'h01);
      capture(60, 1'b0, 8'h00);
      pin("x01_start", int'(cap_line[0][2]), 1);
      pin("x01_bit0", int'(cap_line[0][5]), 1);
      pin("x01_bit1", int'(cap_line[0][9]), 0);
      pin("x01_parity", int'(cap_line[0][37]), 1);
      pin("x01_done45", int'(cap_dn[0][45]), 1);
      pin("x01_done_count", count_done(0, 60), 1);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
